reg_scan_reader: RTL and testbench

REG_SCAN_READER -- requirements
Module: reg_scan_reader

---
 rtl/reg_scan_pkg.sv | 23 ++
 rtl/reg_scan_reader_word_serializer.sv | 43 ++++
 rtl/reg_scan_reader.sv | 113 +++++++++++
 tb/tb_reg_scan_reader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_scan_pkg.sv
// Shared types and constants for the register scan reader.
// Imported by the FSM top and the word serializer.
package reg_scan_pkg;

    localparam int ADDR_W = 5;
    localparam int WORD_W = 32;
    localparam int BYTES_PER_WORD = 4;
    localparam int CNT_W = 2;
    localparam logic [2:0] HDR_TAG = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_SEND_HDR,
        S_SEND_DATA,
        S_DONE
    } state_t;

    function automatic logic [7:0] hdr_byte(input logic [ADDR_W-1:0] addr);
        return {HDR_TAG, addr};
    endfunction

endpackage

// File: rtl/reg_scan_reader_word_serializer.sv
// Holds one fetched register word and walks it out MSB byte first.
// The counter wraps to 0 after the last byte, ready for the next word.
module word_serializer
    import reg_scan_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WORD_W-1:0] din,
    input  logic              advance,
    output logic [7:0]        byte_out,
    output logic              last_byte
);

    logic [WORD_W-1:0] word;
    logic [CNT_W-1:0]  cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
            cnt  <= '0;
        end else if (load) begin
            word <= din;
            cnt  <= '0;
        end else if (advance) begin
            cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        byte_out = word[7:0];
        unique case (cnt)
            2'd0: byte_out = word[31:24];
            2'd1: byte_out = word[23:16];
            2'd2: byte_out = word[15:8];
            2'd3: byte_out = word[7:0];
            default: byte_out = word[7:0];
        endcase
    end

    assign last_byte = (cnt == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/reg_scan_reader.sv
// Scans a range of register file entries and streams them out as
// bytes over a valid/ready link, optionally tagging each with its index.
module reg_scan_reader
    import reg_scan_pkg::*;
#(
    parameter bit HEADER_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] rf_addr,
    input  logic [WORD_W-1:0] rf_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    state_t state, state_nx;

    logic [ADDR_W-1:0] last_q;
    logic              fire;
    logic              load;
    logic              advance;
    logic              last_byte;
    logic              at_end;
    logic              accept;
    logic [7:0]        ser_byte;

    assign fire   = tx_valid & tx_ready;
    assign accept = (state == S_IDLE) & start;
    assign at_end = (rf_addr == last_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Compare before incrementing so a scan ending at 31 never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_addr <= '0;
            last_q  <= '0;
        end else if (accept) begin
            rf_addr <= first_addr;
            last_q  <= last_addr;
        end else if (advance && last_byte && !at_end) begin
            rf_addr <= rf_addr + 1'b1;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: begin
                if (start)
                    state_nx = (first_addr > last_addr) ? S_DONE : S_FETCH;
            end
            S_FETCH: begin
                state_nx = HEADER_EN ? S_SEND_HDR : S_SEND_DATA;
            end
            S_SEND_HDR: begin
                if (fire) state_nx = S_SEND_DATA;
            end
            S_SEND_DATA: begin
                if (fire && last_byte)
                    state_nx = at_end ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        tx_valid = 1'b0;
        tx_data  = '0;
        busy     = 1'b1;
        done     = 1'b0;
        load     = 1'b0;
        advance  = 1'b0;
        unique case (1'b1)
            (state == S_IDLE): busy = 1'b0;
            (state == S_FETCH): load = 1'b1;
            (state == S_SEND_HDR): begin
                tx_valid = 1'b1;
                tx_data  = hdr_byte(rf_addr);
            end
            (state == S_SEND_DATA): begin
                tx_valid = 1'b1;
                tx_data  = ser_byte;
                advance  = tx_ready;
            end
            (state == S_DONE): done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    word_serializer u_ser (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .din       (rf_data),
        .advance   (advance),
        .byte_out  (ser_byte),
        .last_byte (last_byte)
    );

endmodule

// File: tb/tb_reg_scan_reader.sv
// Directed bench for reg_scan_reader: header and headerless instances
// share a register file model and one byte collector.
module tb_reg_scan_reader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start1 = 1'b0;
    logic        start0 = 1'b0;
    logic [4:0]  first_addr = '0;
    logic [4:0]  last_addr = '0;
    logic        tx_ready = 1'b0;

    logic [4:0]  rf_addr1, rf_addr0;
    logic [31:0] rf_data1, rf_data0;
    logic [7:0]  tx_data1, tx_data0;
    logic        tx_valid1, tx_valid0;
    logic        busy1, busy0;
    logic        done1, done0;

    logic [31:0] regs [32];

    assign rf_data1 = regs[rf_addr1];
    assign rf_data0 = regs[rf_addr0];

    always #5 clk = ~clk;

    reg_scan_reader #(.HEADER_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .first_addr(first_addr), .last_addr(last_addr),
        .rf_addr(rf_addr1), .rf_data(rf_data1),
        .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready),
        .busy(busy1), .done(done1)
    );

    reg_scan_reader #(.HEADER_EN(1'b0)) dut_nh (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .first_addr(first_addr), .last_addr(last_addr),
        .rf_addr(rf_addr0), .rf_data(rf_data0),
        .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready),
        .busy(busy0), .done(done0)
    );

    logic       sel = 1'b0;
    logic [4:0] m_addr;
    logic [7:0] m_data;
    logic       m_valid, m_busy, m_done;

    assign m_addr  = sel ? rf_addr0  : rf_addr1;
    assign m_data  = sel ? tx_data0  : tx_data1;
    assign m_valid = sel ? tx_valid0 : tx_valid1;
    assign m_busy  = sel ? busy0     : busy1;
    assign m_done  = sel ? done0     : done1;

    int checks = 0;
    int fails = 0;

    logic [7:0] got [$];
    int   done_cnt, done_cyc, first_v, stall_err, busy_err, vcyc;
    bit   addr0;
    logic post_busy, post_done;
    logic [4:0] post_addr;

    task automatic go(input logic v);
        start1 = sel ? 1'b0 : v;
        start0 = sel ? v : 1'b0;
    endtask

    // poke: raise start mid-scan and again in the DONE cycle
    task automatic run_scan(input logic [4:0] f, input logic [4:0] l,
                            input bit toggle, input bit poke);
        bit prev_stall;
        logic [7:0] prev_data;
        got.delete();
        done_cnt = 0; done_cyc = -1; first_v = -1;
        stall_err = 0; busy_err = 0; vcyc = 0; addr0 = 1'b0;
        prev_stall = 1'b0; prev_data = '0;
        @(negedge clk);
        first_addr = f; last_addr = l; tx_ready = 1'b1; go(1'b1);
        @(negedge clk);
        go(1'b0);
        for (int i = 1; i < 400; i++) begin
            tx_ready = toggle ? i[0] : 1'b1;
            if (poke && i == 4) begin
                first_addr = 5'd1; last_addr = 5'd1; go(1'b1);
            end else begin
                go(1'b0);
            end
            if (m_valid) begin
                vcyc++;
                if (first_v < 0) first_v = i;
                if (prev_stall && m_data !== prev_data) stall_err++;
                if (tx_ready) got.push_back(m_data);
            end
            prev_stall = m_valid && !tx_ready;
            prev_data = m_data;
            if (m_addr == 5'd0) addr0 = 1'b1;
            if (!m_busy) busy_err++;
            if (m_done) begin
                done_cnt++;
                done_cyc = i;
                if (poke) begin
                    first_addr = 5'd1; last_addr = 5'd1; go(1'b1);
                end
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        go(1'b0);
        post_busy = m_busy;
        post_done = m_done;
        post_addr = m_addr;
        @(negedge clk);
        if (m_done) done_cnt++;
    endtask

    task automatic test_reset;
        sel = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (rf_addr1 !== 5'd0) begin fails++; $display("FAIL reset_rf_addr got %h want 00", rf_addr1); end
        checks++; if (tx_valid1 !== 1'b0) begin fails++; $display("FAIL reset_tx_valid got %b want 0", tx_valid1); end
        checks++; if (tx_data1 !== 8'h00) begin fails++; $display("FAIL reset_tx_data got %h want 00", tx_data1); end
        checks++; if (busy1 !== 1'b0 || done1 !== 1'b0) begin fails++; $display("FAIL reset_busy_done got %b%b want 00", busy1, done1); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        logic [7:0] e [] = '{8'hA8, 8'h12, 8'h34, 8'h56, 8'h78};
        sel = 1'b0;
        run_scan(5'd8, 5'd8, 1'b0, 1'b1);
        checks++; if (got.size() != e.size()) begin fails++; $display("FAIL single_len got %0d want %0d", got.size(), e.size()); end
        for (int k = 0; k < e.size(); k++) begin
            checks++;
            if (k >= got.size() || got[k] !== e[k]) begin
                fails++; $display("FAIL single_byte%0d got %h want %h", k, (k < got.size()) ? got[k] : 8'hxx, e[k]);
            end
        end
        checks++; if (first_v != 2) begin fails++; $display("FAIL single_latency got %0d want 2", first_v); end
        checks++; if (done_cyc != 7) begin fails++; $display("FAIL single_done_cycle got %0d want 7", done_cyc); end
        checks++; if (busy_err != 0) begin fails++; $display("FAIL single_busy_low got %0d want 0", busy_err); end
        checks++; if (post_busy !== 1'b0 || post_done !== 1'b0) begin fails++; $display("FAIL single_after_done got %b%b want 00", post_busy, post_done); end
        checks++; if (done_cnt != 1) begin fails++; $display("FAIL single_done_count got %0d want 1", done_cnt); end
    endtask

    task automatic test_stall;
        logic [7:0] e [] = '{8'hA9, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                             8'hAA, 8'h00, 8'h00, 8'h00, 8'h01};
        sel = 1'b0;
        run_scan(5'd9, 5'd10, 1'b1, 1'b0);
        checks++; if (got.size() != e.size()) begin fails++; $display("FAIL stall_len got %0d want %0d", got.size(), e.size()); end
        for (int k = 0; k < e.size(); k++) begin
            checks++;
            if (k >= got.size() || got[k] !== e[k]) begin
                fails++; $display("FAIL stall_byte%0d got %h want %h", k, (k < got.size()) ? got[k] : 8'hxx, e[k]);
            end
        end
        checks++; if (stall_err != 0) begin fails++; $display("FAIL stall_hold got %0d changes want 0", stall_err); end
        checks++; if (vcyc != 19) begin fails++; $display("FAIL stall_valid_cycles got %0d want 19", vcyc); end
        checks++; if (done_cyc != 22) begin fails++; $display("FAIL stall_done_cycle got %0d want 22", done_cyc); end
        checks++; if (done_cnt != 1) begin fails++; $display("FAIL stall_done_count got %0d want 1", done_cnt); end
    endtask

    task automatic test_top_index;
        logic [7:0] e [] = '{8'hBF, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
        sel = 1'b0;
        run_scan(5'd31, 5'd31, 1'b0, 1'b0);
        checks++; if (got.size() != e.size()) begin fails++; $display("FAIL top_len got %0d want %0d", got.size(), e.size()); end
        for (int k = 0; k < e.size(); k++) begin
            checks++;
            if (k >= got.size() || got[k] !== e[k]) begin
                fails++; $display("FAIL top_byte%0d got %h want %h", k, (k < got.size()) ? got[k] : 8'hxx, e[k]);
            end
        end
        checks++; if (addr0 !== 1'b0) begin fails++; $display("FAIL top_no_wrap got %b want 0", addr0); end
        checks++; if (post_addr !== 5'd31) begin fails++; $display("FAIL top_addr_after got %h want 1f", post_addr); end
        checks++; if (done_cyc != 7) begin fails++; $display("FAIL top_done_cycle got %0d want 7", done_cyc); end
    endtask

    task automatic test_empty;
        sel = 1'b0;
        run_scan(5'd5, 5'd3, 1'b0, 1'b0);
        checks++; if (vcyc != 0) begin fails++; $display("FAIL empty_valid_cycles got %0d want 0", vcyc); end
        checks++; if (done_cyc != 1) begin fails++; $display("FAIL empty_done_cycle got %0d want 1", done_cyc); end
        checks++; if (done_cnt != 1) begin fails++; $display("FAIL empty_done_count got %0d want 1", done_cnt); end
    endtask

    task automatic test_reset_mid_scan;
        logic [7:0] e [] = '{8'hA0, 8'h00, 8'h00, 8'h00, 8'h00};
        int seen_done;
        sel = 1'b0;
        got.delete();
        seen_done = 0;
        @(negedge clk);
        first_addr = 5'd0; last_addr = 5'd31; tx_ready = 1'b1; go(1'b1);
        @(negedge clk);
        go(1'b0);
        for (int i = 0; i < 200 && got.size() < 23; i++) begin
            if (tx_valid1) got.push_back(tx_data1);
            if (got.size() < 23) @(negedge clk);
        end
        @(negedge clk);
        checks++; if (rf_addr1 !== 5'd4 || tx_data1 !== 8'h04) begin fails++; $display("FAIL midrst_position got %h/%h want 04/04", rf_addr1, tx_data1); end
        rst_n = 1'b0;
        #1;
        checks++; if (tx_valid1 !== 1'b0 || tx_data1 !== 8'h00) begin fails++; $display("FAIL midrst_tx got %b/%h want 0/00", tx_valid1, tx_data1); end
        checks++; if (rf_addr1 !== 5'd0 || busy1 !== 1'b0 || done1 !== 1'b0) begin fails++; $display("FAIL midrst_state got %h%b%b want 0000", rf_addr1, busy1, done1); end
        repeat (3) begin
            @(negedge clk);
            if (done1) seen_done++;
        end
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (done1 || busy1) seen_done++;
        end
        checks++; if (seen_done != 0) begin fails++; $display("FAIL midrst_no_done got %0d want 0", seen_done); end
        run_scan(5'd0, 5'd0, 1'b0, 1'b0);
        checks++; if (got.size() != e.size()) begin fails++; $display("FAIL midrst_len got %0d want %0d", got.size(), e.size()); end
        for (int k = 0; k < e.size(); k++) begin
            checks++;
            if (k >= got.size() || got[k] !== e[k]) begin
                fails++; $display("FAIL midrst_byte%0d got %h want %h", k, (k < got.size()) ? got[k] : 8'hxx, e[k]);
            end
        end
    endtask

    task automatic test_no_header;
        logic [7:0] e [] = '{8'h12, 8'h34, 8'h56, 8'h78,
                             8'hDE, 8'hAD, 8'hBE, 8'hEF};
        sel = 1'b1;
        run_scan(5'd8, 5'd9, 1'b0, 1'b1);
        checks++; if (got.size() != e.size()) begin fails++; $display("FAIL nohdr_len got %0d want %0d", got.size(), e.size()); end
        for (int k = 0; k < e.size(); k++) begin
            checks++;
            if (k >= got.size() || got[k] !== e[k]) begin
                fails++; $display("FAIL nohdr_byte%0d got %h want %h", k, (k < got.size()) ? got[k] : 8'hxx, e[k]);
            end
        end
        checks++; if (done_cyc != 11) begin fails++; $display("FAIL nohdr_done_cycle got %0d want 11", done_cyc); end
        checks++; if (first_v != 2) begin fails++; $display("FAIL nohdr_latency got %0d want 2", first_v); end
        checks++; if (post_busy !== 1'b0) begin fails++; $display("FAIL nohdr_start_in_done got %b want 0", post_busy); end
        checks++; if (busy_err != 0 || done_cnt != 1) begin fails++; $display("FAIL nohdr_busy_done got %0d/%0d want 0/1", busy_err, done_cnt); end
        sel = 1'b0;
    endtask

    initial begin
        for (int k = 0; k < 32; k++) regs[k] = 32'h01010101 * k;
        regs[0]  = 32'h00000000;
        regs[8]  = 32'h12345678;
        regs[9]  = 32'hDEADBEEF;
        regs[10] = 32'h00000001;
        regs[31] = 32'hCAFEF00D;
        test_reset;
        test_single;
        test_stall;
        test_top_index;
        test_empty;
        test_reset_mid_scan;
        test_no_header;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
